// File: rtl/sqrt_iter_core.sv
// Iterative restoring integer square root, one root bit per clock, with
// valid/ready handshakes on operand and result plus a hex glyph of the last root.
//
// state | meaning
// IDLE  | waiting for an operand, in_ready high
// CALC  | producing one root bit per edge, counter counts down to zero
// DONE  | result presented, held until out_ready
module sqrt_iter_core #(
    parameter int WIDTH = 7,
    localparam int RW = (WIDTH + 1) / 2
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [WIDTH-1:0]  i_in_data,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [RW-1:0]     o_out_root,
    output logic [RW:0]       o_out_rem,
    output logic [6:0]        o_seg,
    output logic              o_seg_dp
);

    localparam int OPW = 2 * RW;
    localparam int CW  = (RW > 1) ? $clog2(RW) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]     r_state;
    logic [OPW-1:0] r_op;
    logic [RW-1:0]  r_root;
    logic [RW+1:0]  r_rem;
    logic [CW-1:0]  r_cnt;
    logic [RW-1:0]  r_out_root;
    logic [RW:0]    r_out_rem;
    logic [6:0]     r_seg;

    logic [RW+1:0]  w_rem_sh;
    logic [RW+1:0]  w_trial;
    logic           w_ge;
    logic [RW+1:0]  w_rem_nx;
    logic [RW-1:0]  w_root_nx;

    function automatic logic [6:0] f_glyph(input logic [3:0] v);
        logic [6:0] g;
        case (v)
            4'h0: g = 7'h3F;  4'h1: g = 7'h06;  4'h2: g = 7'h5B;  4'h3: g = 7'h4F;
            4'h4: g = 7'h66;  4'h5: g = 7'h6D;  4'h6: g = 7'h7D;  4'h7: g = 7'h07;
            4'h8: g = 7'h7F;  4'h9: g = 7'h6F;  4'hA: g = 7'h77;  4'hB: g = 7'h7C;
            4'hC: g = 7'h39;  4'hD: g = 7'h5E;  4'hE: g = 7'h79;  default: g = 7'h71;
        endcase
        return g;
    endfunction

    // Remainder only needs RW bits between steps; the top two give the compare headroom.
    always_comb begin
        w_rem_sh  = (r_rem << 2) | {{RW{1'b0}}, r_op[OPW-1 -: 2]};
        w_trial   = {r_root, 2'b01};
        w_ge      = (w_rem_sh >= w_trial);
        w_rem_nx  = w_ge ? (w_rem_sh - w_trial) : w_rem_sh;
        w_root_nx = {r_root[RW-2:0], w_ge};
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= IDLE;
            r_op       <= '0;
            r_root     <= '0;
            r_rem      <= '0;
            r_cnt      <= '0;
            r_out_root <= '0;
            r_out_rem  <= '0;
            r_seg      <= 7'h3F;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_in_valid) begin
                        r_op    <= OPW'(i_in_data);
                        r_root  <= '0;
                        r_rem   <= '0;
                        r_cnt   <= CW'(RW - 1);
                        r_state <= CALC;
                    end
                end
                CALC: begin
                    r_op   <= r_op << 2;
                    r_root <= w_root_nx;
                    r_rem  <= w_rem_nx;
                    r_cnt  <= r_cnt - 1'b1;
                    if (r_cnt == '0) begin
                        r_out_root <= w_root_nx;
                        r_out_rem  <= w_rem_nx[RW:0];
                        r_seg      <= f_glyph(4'(w_root_nx));
                        r_state    <= DONE;
                    end
                end
                DONE: begin
                    if (i_out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_in_ready  = (r_state == IDLE);
    assign o_out_valid = (r_state == DONE);
    assign o_out_root  = r_out_root;
    assign o_out_rem   = r_out_rem;
    assign o_seg       = r_seg;
    assign o_seg_dp    = (r_state == DONE);

endmodule
